add_rs: RTL and testbench
=========================

# add_rs

Adder reservation-station bank: the receiving end of the dispatch unit's issue buses and the driver of the adder result bus. It holds stations A0–A2 (tags 0x20–0x22) and captures ADD instructions issued on `instbus1` and `instbus2`. It resolves source operands from the register file or by snooping the add, mult and load result buses, executes the ready stations on one pipelined 32-bit adder, and broadcasts `{tag, value}` on `addbus`. That broadcast is what frees the station in dispatch and clears its register tag.

## Interface
- `LATENCY`, default 2: adder pipeline stages (1–4).
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instbus1` in 40: issue word. [39:32] station tag, [31:24] opcode, [23:16] operand 1 code, [15:8] operand 2 code, [7:0] destination register.
- `instbus1_vld` in 1: one-cycle pulse, `instbus1` is a new issue.
- `instbus2` in 40: second issue word, same format.
- `instbus2_vld` in 1: one-cycle pulse for `instbus2`.
- `regs` in 128: architectural register values. R0 [31:0], R1 [63:32], R2 [95:64], R3 [127:96].
- `multbus` in 40: multiplier result bus. [39:32] tag (0 = idle), [31:0] value.
- `loadbus` in 40: load result bus, same format.
- `addbus` out 40: registered adder result bus, same format. Reset value 0.
- `busy` out 3: per-station occupied, bit i = Ai. Reset value 0.
- `collision_err` out 1: registered one-cycle pulse. Reset value 0.
- `ill_op` out 1: registered one-cycle pulse. Reset value 0.

## Operation
- **Accepting an issue.** An issue is accepted when its vld is high, its tag is 0x20–0x22, its opcode is 0x03 (ADD), and the target station is FREE.
  - A vld issue whose tag is outside 0x20–0x22 is ignored silently, because it belongs to another unit.
- **Rejected issues.**
  - Target station not FREE: issue is dropped and `collision_err` pulses.
  - Both buses target the same station in the same cycle: `instbus1` wins, `instbus2` is dropped and `collision_err` pulses.
  - Opcode not accepted (see Configuration): station is not allocated and `ill_op` pulses.
- **Operand resolution at capture.**
  - Code 0x10–0x13: value is taken from `regs`; operand is ready.
  - Any other nonzero code is a tag.
    - If `addbus`, `multbus` or `loadbus` carries that tag in the capture cycle, its value is taken (forwarding) and the operand is ready.
    - Otherwise the operand waits and takes the value from the first matching bus broadcast.
  - Code 0x00: value 0, ready, and `ill_op` pulses.
- **Station states.**
  - FREE → WAIT on accept when any operand is waiting; FREE → READY when both are ready.
  - WAIT → READY once both operands are captured.
  - READY → EXEC when selected by the arbiter.
  - EXEC → FREE at the edge that drives this station's broadcast.
- **Arbiter.** Each cycle it selects the lowest-index READY station and feeds it into the pipeline; at most one station starts per cycle.
- **Arithmetic.** Result = op1 + op2, modulo 2^32; carry is discarded.
- **Broadcast.** `addbus` = {station tag, result} for exactly one cycle. The bus is 0 in idle cycles.
- **Reset.** Reset is legal at any time. It returns all stations to FREE, flushes the pipeline, and drives all outputs to 0.

## Timing
- Issue sampled at edge N.
- A station that is READY after edge N can be selected at edge N+1.
- Its broadcast is visible from edge N+1+LATENCY for one cycle. Minimum issue-to-broadcast latency is therefore LATENCY+1 cycles.
- `busy[i]` goes high at the capture edge. It goes low at the edge that drives the broadcast; the same edge sets `addbus` and frees the station.
- A re-issue to a station is accepted from the cycle after its broadcast.
- A waiting operand captured from a bus at edge M makes the station READY after edge M, so it can be selected at edge M+1.
- `addbus` feeds back into operand snooping. This allows one station to consume another's result.

## Configuration
- `ADD_RS_SUB_EN`
  - Defined: opcode 0x05 (SUB) is also accepted, and the result is op1 − op2 modulo 2^32. Each station keeps an op bit that is carried through the pipeline.
  - Undefined: opcode 0x05 is rejected with `ill_op` and the station is not allocated.

## Structure
- Package `add_rs_pkg` holds:
  - tag constants A0/A1/A2/M0/M1/LD0/LD1 and register codes R0–R3;
  - opcodes LOAD/STORE/ADD/MULTI/SUB;
  - the result-bus field positions;
  - the station-state enum FREE/WAIT/READY/EXEC.
- Sub-module `add_pipe`: a LATENCY-stage registered adder carrying {valid, tag, op} alongside the data, with asynchronous clear.

## Test plan
- Single issue with LATENCY=2: `instbus1` = {0x20, 0x03, 0x10, 0x11, 0x12}, R0=5, R1=7, vld at edge 0. Expect `addbus` = {0x20, 12} after edge 3, and `busy`=000 after edge 3.
- Dependency: issue 1 to A1 with operand 1 = 0x30, plus an immediate ADD to A0. `multbus` = {0x30, 100} at edge 5. Expect A1 READY after edge 5 and broadcast {0x21, 100 + op2} after edge 8; A0 broadcasts first.
- Dual issue: A0 and A1 on both buses in the same cycle, all operands ready. Expect the A0 broadcast followed by A1 on the next cycle.
- Collision: issue to A2 while it is busy. Expect `collision_err` pulse; A2 contents are unchanged and its original result is broadcast.
- Wrap-around and opcode: operands 0xFFFFFFFF + 2 gives result 1. Opcode 0x05 gives `ill_op` without the macro, and op1 − op2 with it.
- Reset mid-operation: assert `rst_n` low while two stations are in EXEC. Expect `addbus`=0 and `busy`=0 immediately, and no broadcast after release.

Source files
------------

// File: rtl/add_rs_pkg.sv
// Shared constants and types for the adder reservation-station bank.
// Result buses are {tag[7:0], value[31:0]}; a tag of 0 means the bus is idle.
package add_rs_pkg;

  localparam int NUM_RS = 3;

  // Station / functional-unit tags
  localparam logic [7:0] TAG_A0  = 8'h20;
  localparam logic [7:0] TAG_A1  = 8'h21;
  localparam logic [7:0] TAG_A2  = 8'h22;
  localparam logic [7:0] TAG_M0  = 8'h30;
  localparam logic [7:0] TAG_M1  = 8'h31;
  localparam logic [7:0] TAG_LD0 = 8'h40;
  localparam logic [7:0] TAG_LD1 = 8'h41;

  // Operand codes naming architectural registers
  localparam logic [7:0] REG_R0 = 8'h10;
  localparam logic [7:0] REG_R1 = 8'h11;
  localparam logic [7:0] REG_R2 = 8'h12;
  localparam logic [7:0] REG_R3 = 8'h13;

  // Opcodes
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;
  localparam logic [7:0] OP_SUB   = 8'h05;

  // Result-bus field positions
  localparam int BUS_TAG_MSB = 39;
  localparam int BUS_TAG_LSB = 32;
  localparam int BUS_VAL_MSB = 31;
  localparam int BUS_VAL_LSB = 0;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } rs_state_e;

  typedef struct packed {
    rs_state_e   state;
    logic        op;      // 1 = subtract
    logic        rdy1;
    logic        rdy2;
    logic [7:0]  src1;
    logic [7:0]  src2;
    logic [31:0] val1;
    logic [31:0] val2;
  } rs_entry_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] val;
  } opnd_t;

  typedef struct packed {
    logic        vld;
    logic [7:0]  tag;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } pipe_stage_t;

  // Look for an operand tag on the three result buses; addbus has priority.
  function automatic opnd_t snoop(input logic [7:0] code, input logic [39:0] ab,
                                  input logic [39:0] mb, input logic [39:0] lb);
    opnd_t r;
    r = '0;
    if (ab[BUS_TAG_MSB:BUS_TAG_LSB] == code) begin
      r.rdy = 1'b1;
      r.val = ab[BUS_VAL_MSB:BUS_VAL_LSB];
    end else if (mb[BUS_TAG_MSB:BUS_TAG_LSB] == code) begin
      r.rdy = 1'b1;
      r.val = mb[BUS_VAL_MSB:BUS_VAL_LSB];
    end else if (lb[BUS_TAG_MSB:BUS_TAG_LSB] == code) begin
      r.rdy = 1'b1;
      r.val = lb[BUS_VAL_MSB:BUS_VAL_LSB];
    end
    return r;
  endfunction

endpackage

// File: rtl/add_pipe.sv
// LATENCY-stage registered adder. Operands, tag and op bit travel together;
// the add/subtract is formed from the last stage so the owner can register it.
module add_pipe
  import add_rs_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [7:0]  in_tag,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_vld,
  output logic [7:0]  out_tag,
  output logic [31:0] out_res
);

  pipe_stage_t stage_q [LATENCY];

  // Shift register of in-flight operations, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{in_vld, in_tag, in_op, in_a, in_b};
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Final-stage arithmetic; carry out is discarded
  always_comb begin
    out_vld = stage_q[LATENCY-1].vld;
    out_tag = stage_q[LATENCY-1].tag;
    out_res = stage_q[LATENCY-1].op ? (stage_q[LATENCY-1].a - stage_q[LATENCY-1].b)
                                    : (stage_q[LATENCY-1].a + stage_q[LATENCY-1].b);
  end

endmodule

// File: rtl/add_rs.sv
// Adder reservation-station bank, stations A0..A2.
// Optional feature macro: ADD_RS_SUB_EN (adds SUB, opcode 0x05).
//
// state | meaning
// FREE  | station empty, may accept an issue
// WAIT  | allocated, at least one operand still snooping the result buses
// READY | both operands held, waiting for the arbiter
// EXEC  | in the adder pipeline; freed when its result is broadcast
module add_rs
  import add_rs_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [39:0]  instbus1,
  input  logic         instbus1_vld,
  input  logic [39:0]  instbus2,
  input  logic         instbus2_vld,
  input  logic [127:0] regs,
  input  logic [39:0]  multbus,
  input  logic [39:0]  loadbus,
  output logic [39:0]  addbus,
  output logic [2:0]   busy,
  output logic         collision_err,
  output logic         ill_op
);

  rs_entry_t   rs_q [NUM_RS];
  rs_entry_t   rs_d [NUM_RS];
  logic        coll_d, ill_d;
  logic        pin_vld, pin_op;
  logic [7:0]  pin_tag;
  logic [31:0] pin_a, pin_b;
  logic        pout_vld;
  logic [7:0]  pout_tag;
  logic [31:0] pout_res;

  // Destination registers are tracked by dispatch, not here.
  logic unused_dst;
  assign unused_dst = ^{instbus1[7:0], instbus2[7:0]};

  function automatic opnd_t resolve(input logic [7:0] code, input logic [127:0] rf,
                                    input logic [39:0] ab, input logic [39:0] mb,
                                    input logic [39:0] lb);
    opnd_t r;
    r = '0;
    if (code == 8'h00) begin
      r.rdy = 1'b1;
    end else if (code >= REG_R0 && code <= REG_R3) begin
      r.rdy = 1'b1;
      r.val = rf[{code[1:0], 5'b0} +: 32];
    end else begin
      r = snoop(code, ab, mb, lb);
    end
    return r;
  endfunction

  add_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (pin_vld),
    .in_tag  (pin_tag),
    .in_op   (pin_op),
    .in_a    (pin_a),
    .in_b    (pin_b),
    .out_vld (pout_vld),
    .out_tag (pout_tag),
    .out_res (pout_res)
  );

  // Station next-state: broadcast free, operand snoop, arbiter, then issue capture
  always_comb begin
    logic [39:0] iw;
    logic        iv, dup, op_ok, is_sub, found;
    logic [7:0]  tag, opc, c1, c2;
    opnd_t       o1, o2;

    for (int i = 0; i < NUM_RS; i++) rs_d[i] = rs_q[i];
    coll_d  = 1'b0;
    ill_d   = 1'b0;
    pin_vld = 1'b0;
    pin_op  = 1'b0;
    pin_tag = '0;
    pin_a   = '0;
    pin_b   = '0;
    iw      = '0;
    iv      = 1'b0;
    op_ok   = 1'b0;
    is_sub  = 1'b0;
    found   = 1'b0;
    tag     = '0;
    opc     = '0;
    c1      = '0;
    c2      = '0;
    o1      = '0;
    o2      = '0;

    for (int i = 0; i < NUM_RS; i++) begin
      if (pout_vld && pout_tag == TAG_A0 + 8'(i)) rs_d[i].state = FREE;
    end

    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_q[i].state == WAIT) begin
        if (!rs_q[i].rdy1) begin
          o1 = snoop(rs_q[i].src1, addbus, multbus, loadbus);
          rs_d[i].rdy1 = o1.rdy;
          if (o1.rdy) rs_d[i].val1 = o1.val;
        end
        if (!rs_q[i].rdy2) begin
          o2 = snoop(rs_q[i].src2, addbus, multbus, loadbus);
          rs_d[i].rdy2 = o2.rdy;
          if (o2.rdy) rs_d[i].val2 = o2.val;
        end
        if (rs_d[i].rdy1 && rs_d[i].rdy2) rs_d[i].state = READY;
      end
    end

    for (int i = 0; i < NUM_RS; i++) begin
      if (!found && rs_q[i].state == READY) begin
        found         = 1'b1;
        rs_d[i].state = EXEC;
        pin_vld       = 1'b1;
        pin_tag       = TAG_A0 + 8'(i);
        pin_op        = rs_q[i].op;
        pin_a         = rs_q[i].val1;
        pin_b         = rs_q[i].val2;
      end
    end

    dup = instbus1_vld && instbus2_vld && (instbus1[39:32] == instbus2[39:32]) &&
          (instbus1[39:32] >= TAG_A0) && (instbus1[39:32] <= TAG_A2);

    for (int b = 0; b < 2; b++) begin
      iw  = (b == 0) ? instbus1 : instbus2;
      iv  = (b == 0) ? instbus1_vld : instbus2_vld;
      tag = iw[39:32];
      opc = iw[31:24];
      c1  = iw[23:16];
      c2  = iw[15:8];
`ifdef ADD_RS_SUB_EN
      is_sub = (opc == OP_SUB);
      op_ok  = (opc == OP_ADD) || is_sub;
`else
      is_sub = 1'b0;
      op_ok  = (opc == OP_ADD);
`endif
      if (iv && tag >= TAG_A0 && tag <= TAG_A2) begin
        if (b == 1 && dup) begin
          coll_d = 1'b1;
        end else if (!op_ok) begin
          ill_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_RS; i++) begin
            if (tag == TAG_A0 + 8'(i)) begin
              if (rs_q[i].state != FREE) begin
                coll_d = 1'b1;
              end else begin
                o1 = resolve(c1, regs, addbus, multbus, loadbus);
                o2 = resolve(c2, regs, addbus, multbus, loadbus);
                rs_d[i].op    = is_sub;
                rs_d[i].src1  = c1;
                rs_d[i].src2  = c2;
                rs_d[i].rdy1  = o1.rdy;
                rs_d[i].rdy2  = o2.rdy;
                rs_d[i].val1  = o1.val;
                rs_d[i].val2  = o2.val;
                rs_d[i].state = (o1.rdy && o2.rdy) ? READY : WAIT;
                if (c1 == 8'h00 || c2 == 8'h00) ill_d = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Station registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) rs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) rs_q[i] <= rs_d[i];
    end
  end

  // Registered result bus and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addbus        <= '0;
      collision_err <= 1'b0;
      ill_op        <= 1'b0;
    end else begin
      addbus        <= pout_vld ? {pout_tag, pout_res} : 40'h0;
      collision_err <= coll_d;
      ill_op        <= ill_d;
    end
  end

  // A station is busy from capture until its broadcast edge
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_RS; i++) busy[i] = (rs_q[i].state != FREE);
  end

endmodule

// File: tb/tb_add_rs.sv
// Self-checking bench for add_rs (LATENCY = 2): vector table, directed
// multi-cycle sequences and a randomized scoreboard run.
module tb_add_rs;
  import add_rs_pkg::*;

  localparam int LAT = 2;

  logic         clk, rst_n;
  logic [39:0]  instbus1, instbus2, multbus, loadbus, addbus;
  logic         instbus1_vld, instbus2_vld;
  logic [127:0] regs;
  logic [2:0]   busy;
  logic         collision_err, ill_op;
  logic [31:0]  rf [4];

  int n_pass  = 0;
  int n_total = 0;

  assign regs = {rf[3], rf[2], rf[1], rf[0]};

  add_rs #(.LATENCY(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instbus1      (instbus1),
    .instbus1_vld  (instbus1_vld),
    .instbus2      (instbus2),
    .instbus2_vld  (instbus2_vld),
    .regs          (regs),
    .multbus       (multbus),
    .loadbus       (loadbus),
    .addbus        (addbus),
    .busy          (busy),
    .collision_err (collision_err),
    .ill_op        (ill_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] iw(input logic [7:0] tag, input logic [7:0] opc,
                                     input logic [7:0] c1, input logic [7:0] c2);
    return {tag, opc, c1, c2, 8'h12};
  endfunction

  // Value an operand code resolves to from the register file
  function automatic logic [31:0] rv(input logic [7:0] c);
    if (c == 8'h00) return 32'h0;
    return rf[c[1:0]];
  endfunction

  task automatic issue(input logic [39:0] w1, input logic v1, input logic [39:0] w2,
                       input logic v2);
    instbus1 = w1; instbus1_vld = v1;
    instbus2 = w2; instbus2_vld = v2;
    tick();
    instbus1_vld = 1'b0;
    instbus2_vld = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  opc, c1, c2;
    logic [31:0] a, b;
    logic        exp_ill, exp_alloc;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [7];

  logic [2:0]  pend;
  logic [31:0] expv [3];
  int          age  [3];

  initial begin
    rst_n = 1'b0;
    instbus1 = '0; instbus2 = '0; instbus1_vld = 1'b0; instbus2_vld = 1'b0;
    multbus = '0; loadbus = '0;
    rf[0] = 0; rf[1] = 0; rf[2] = 32'hDEAD0000; rf[3] = 32'h0000BEEF;

    vecs[0] = '{OP_ADD,   REG_R0, REG_R1, 32'd5,        32'd7,        1'b0, 1'b1, 32'd12};
    vecs[1] = '{OP_ADD,   REG_R0, REG_R1, 32'hFFFFFFFF, 32'd2,        1'b0, 1'b1, 32'd1};
    vecs[2] = '{OP_ADD,   8'h00,  REG_R1, 32'd9,        32'd30,       1'b1, 1'b1, 32'd30};
`ifdef ADD_RS_SUB_EN
    vecs[3] = '{OP_SUB,   REG_R0, REG_R1, 32'd50,       32'd8,        1'b0, 1'b1, 32'd42};
`else
    vecs[3] = '{OP_SUB,   REG_R0, REG_R1, 32'd50,       32'd8,        1'b1, 1'b0, 32'd0};
`endif
    vecs[4] = '{OP_ADD,   REG_R1, REG_R1, 32'd0,        32'h80000000, 1'b0, 1'b1, 32'd0};
    vecs[5] = '{OP_ADD,   REG_R0, REG_R1, 32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789};
    vecs[6] = '{OP_MULTI, REG_R0, REG_R1, 32'd1,        32'd1,        1'b1, 1'b0, 32'd0};

    #12;
    chk("rst_addbus", addbus, 40'h0);
    chk("rst_busy", {37'h0, busy}, 40'h0);
    chk("rst_coll", {39'h0, collision_err}, 40'h0);
    chk("rst_ill", {39'h0, ill_op}, 40'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Vector table: single issue to A0, broadcast expected after edge 3
    for (int k = 0; k < 7; k++) begin
      rf[0] = vecs[k].a;
      rf[1] = vecs[k].b;
      issue(iw(TAG_A0, vecs[k].opc, vecs[k].c1, vecs[k].c2), 1'b1, 40'h0, 1'b0);
      chk($sformatf("vec%0d_busy0", k), {37'h0, busy}, {39'h0, vecs[k].exp_alloc});
      chk($sformatf("vec%0d_ill", k), {39'h0, ill_op}, {39'h0, vecs[k].exp_ill});
      tick();
      tick();
      chk($sformatf("vec%0d_early", k), addbus, 40'h0);
      tick();
      chk($sformatf("vec%0d_bus", k), addbus,
          vecs[k].exp_alloc ? {TAG_A0, vecs[k].exp_val} : 40'h0);
      chk($sformatf("vec%0d_busy3", k), {37'h0, busy}, 40'h0);
      tick();
      chk($sformatf("vec%0d_idle", k), addbus, 40'h0);
    end

    // Dependency on a multiplier tag; A0 independent
    rf[0] = 3; rf[1] = 40;
    issue(iw(TAG_A1, OP_ADD, TAG_M0, REG_R1), 1'b1, iw(TAG_A0, OP_ADD, REG_R0, REG_R1), 1'b1);
    chk("dep_busy0", {37'h0, busy}, 40'h3);
    tick(); tick(); tick();
    chk("dep_a0_bus", addbus, {TAG_A0, 32'd43});
    chk("dep_busy3", {37'h0, busy}, 40'h2);
    tick();
    chk("dep_idle4", addbus, 40'h0);
    multbus = {TAG_M0, 32'd100};
    tick();
    multbus = '0;
    tick(); tick();
    chk("dep_idle7", addbus, 40'h0);
    tick();
    chk("dep_a1_bus", addbus, {TAG_A1, 32'd140});
    chk("dep_busy8", {37'h0, busy}, 40'h0);
    tick();

    // Dual issue, both ready
    rf[0] = 10; rf[1] = 20; rf[2] = 1; rf[3] = 2;
    issue(iw(TAG_A0, OP_ADD, REG_R0, REG_R1), 1'b1, iw(TAG_A1, OP_ADD, REG_R2, REG_R3), 1'b1);
    chk("dual_busy0", {37'h0, busy}, 40'h3);
    tick(); tick(); tick();
    chk("dual_a0", addbus, {TAG_A0, 32'd30});
    tick();
    chk("dual_a1", addbus, {TAG_A1, 32'd3});
    chk("dual_busy4", {37'h0, busy}, 40'h0);
    tick();
    chk("dual_idle", addbus, 40'h0);

    // Both buses target A0: bus1 wins
    issue(iw(TAG_A0, OP_ADD, REG_R0, REG_R0), 1'b1, iw(TAG_A0, OP_ADD, REG_R1, REG_R1), 1'b1);
    chk("same_coll", {39'h0, collision_err}, 40'h1);
    chk("same_busy", {37'h0, busy}, 40'h1);
    tick();
    chk("same_coll_end", {39'h0, collision_err}, 40'h0);
    tick(); tick();
    chk("same_bus", addbus, {TAG_A0, 32'd20});
    tick();

    // Re-issue to busy A2
    issue(iw(TAG_A2, OP_ADD, REG_R2, REG_R3), 1'b1, 40'h0, 1'b0);
    issue(iw(TAG_A2, OP_ADD, REG_R0, REG_R1), 1'b1, 40'h0, 1'b0);
    chk("coll_pulse", {39'h0, collision_err}, 40'h1);
    chk("coll_busy", {37'h0, busy}, 40'h4);
    tick();
    chk("coll_pulse_end", {39'h0, collision_err}, 40'h0);
    tick();
    chk("coll_bus", addbus, {TAG_A2, 32'd3});
    chk("coll_busy3", {37'h0, busy}, 40'h0);
    tick();
    chk("coll_idle", addbus, 40'h0);

    // Chaining through addbus snoop
    issue(iw(TAG_A0, OP_ADD, REG_R0, REG_R1), 1'b1, 40'h0, 1'b0);
    issue(iw(TAG_A1, OP_ADD, TAG_A0, REG_R2), 1'b1, 40'h0, 1'b0);
    tick(); tick();
    chk("chain_a0", addbus, {TAG_A0, 32'd30});
    tick(); tick(); tick();
    chk("chain_idle6", addbus, 40'h0);
    tick();
    chk("chain_a1", addbus, {TAG_A1, 32'd31});
    tick();

    // Reset with two stations in EXEC
    issue(iw(TAG_A0, OP_ADD, REG_R0, REG_R1), 1'b1, iw(TAG_A1, OP_ADD, REG_R2, REG_R3), 1'b1);
    tick(); tick();
    chk("rstx_busy_pre", {37'h0, busy}, 40'h3);
    rst_n = 1'b0;
    #1;
    chk("rstx_busy", {37'h0, busy}, 40'h0);
    chk("rstx_bus", addbus, 40'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rstx_quiet", addbus | {37'h0, busy}, 40'h0);
    end
    // Reset while a broadcast is on the bus
    issue(iw(TAG_A0, OP_ADD, REG_R0, REG_R1), 1'b1, 40'h0, 1'b0);
    tick(); tick(); tick();
    chk("rsty_pre", addbus, {TAG_A0, 32'd30});
    rst_n = 1'b0;
    #1;
    chk("rsty_bus", addbus, 40'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized run against a scoreboard of expected results per station
    pend = '0;
    for (int i = 0; i < 3; i++) begin expv[i] = 0; age[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [2:0]  newp;
      logic        exp_ill;
      logic [7:0]  c1, c2;
      int          s1, s2;
      newp = '0;
      exp_ill = 1'b0;
      s1 = -1;
      for (int r = 0; r < 4; r++) rf[r] = $urandom;
      instbus1_vld = 1'b0;
      instbus2_vld = 1'b0;
      if (cyc < 380 && $urandom_range(0, 1) == 1) begin
        s1 = $urandom_range(0, 2);
        if (!pend[s1]) begin
          c1 = ($urandom_range(0, 7) == 0) ? 8'h00 : REG_R0 + 8'($urandom_range(0, 3));
          c2 = ($urandom_range(0, 7) == 0) ? 8'h00 : REG_R0 + 8'($urandom_range(0, 3));
          expv[s1] = rv(c1) + rv(c2);
          if (c1 == 8'h00 || c2 == 8'h00) exp_ill = 1'b1;
          instbus1 = iw(TAG_A0 + 8'(s1), OP_ADD, c1, c2);
          instbus1_vld = 1'b1;
          newp[s1] = 1'b1;
        end
      end
      if (cyc < 380 && $urandom_range(0, 2) == 0) begin
        s2 = $urandom_range(0, 2);
        if (!pend[s2] && !newp[s2]) begin
          c1 = ($urandom_range(0, 7) == 0) ? 8'h00 : REG_R0 + 8'($urandom_range(0, 3));
          c2 = REG_R0 + 8'($urandom_range(0, 3));
          expv[s2] = rv(c1) + rv(c2);
          if (c1 == 8'h00) exp_ill = 1'b1;
          instbus2 = iw(TAG_A0 + 8'(s2), OP_ADD, c1, c2);
          instbus2_vld = 1'b1;
          newp[s2] = 1'b1;
        end
      end
      tick();
      instbus1_vld = 1'b0;
      instbus2_vld = 1'b0;
      if (addbus != 40'h0) begin
        int t;
        t = int'(addbus[39:32]) - int'(TAG_A0);
        if (t >= 0 && t < 3 && pend[t]) begin
          chk("rand_bus", addbus, {TAG_A0 + 8'(t), expv[t]});
          pend[t] = 1'b0;
        end else begin
          chk("rand_unexpected_bus", addbus, 40'h0);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) begin
          age[i]++;
          if (age[i] > LAT + 6) begin
            chk("rand_timeout_age", 40'(age[i]), 40'(LAT + 6));
            pend[i] = 1'b0;
          end
        end
        if (newp[i]) begin
          pend[i] = 1'b1;
          age[i] = 0;
        end
      end
      chk("rand_busy", {37'h0, busy}, {37'h0, pend});
      chk("rand_ill", {39'h0, ill_op}, {39'h0, exp_ill});
      chk("rand_coll", {39'h0, collision_err}, 40'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
